mmio_switch_input: RTL and testbench

- Memory-mapped input peripheral on the CPU data-memory port, beside `ram`.
- It is the input counterpart of the syscall-print/seven-segment output path: the CPU reads operator-entered values through it.
- It debounces a push button. On each accepted press it captures the switch bank into a FIFO.
- The CPU reads that FIFO with ordinary loads, which return data with the same one-cycle synchronous-read timing as `ram`.

---
 rtl/mmio_pkg.sv | 26 ++
 rtl/mmio_switch_input_btn_debounce.sv | 93 +++++++++
 rtl/mmio_switch_input.sv | 145 ++++++++++++++
 tb/tb_mmio_switch_input.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped switch-input peripheral:
// register offsets, STATUS/CTRL bit positions and the debounce state encoding.
package mmio_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_EVCNT  = 2'd3;

   localparam int STAT_NONEMPTY = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_OVF      = 2;
   localparam int STAT_CNT_LSB  = 4;
   localparam int STAT_CNT_W    = 5;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

   typedef enum logic [1:0] {
      DB_IDLE  = 2'd0,
      DB_PRESS = 2'd1,
      DB_HELD  = 2'd2,
      DB_REL   = 2'd3
   } db_state_e;

endpackage

// File: rtl/mmio_switch_input_btn_debounce.sv
// Two-flop synchronisers for the button and switch bank, plus the press/release
// debounce FSM that emits one registered accept pulse per clean press.
module btn_debounce
   import mmio_pkg::*;
#(
   parameter int SW_W      = 6,
   parameter int DB_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btn,
   input  logic [SW_W-1:0] sw,
   output logic [SW_W-1:0] sw_sync,
   output logic            accept
);

   localparam int            CW       = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic            btn_s1_q, btn_s2_q;
   logic [SW_W-1:0] sw_s1_q, sw_s2_q;
   db_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            accept_q, accept_d;

   // NOTE: sequential state uses <= so every flop samples pre-edge values,
   // independent of statement order inside the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1_q <= 1'b0;
         btn_s2_q <= 1'b0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         state_q  <= DB_IDLE;
         cnt_q    <= '0;
         accept_q <= 1'b0;
      end else begin
         btn_s1_q <= btn;
         btn_s2_q <= btn_s1_q;
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         accept_q <= accept_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first, so no path through the
      // case leaves it unassigned and infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_d = 1'b0;
      unique case (state_q)
         DB_IDLE: begin
            if (btn_s2_q) begin
               state_d = DB_PRESS;
               cnt_d   = '0;
            end
         end
         DB_PRESS: begin
            if (!btn_s2_q) begin
               state_d = DB_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = DB_HELD;
               accept_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DB_HELD: begin
            if (!btn_s2_q) begin
               state_d = DB_REL;
               cnt_d   = '0;
            end
         end
         DB_REL: begin
            // A re-press during release settling returns to HELD without a new accept.
            if (btn_s2_q) begin
               state_d = DB_HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DB_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   assign sw_sync = sw_s2_q;
   assign accept  = accept_q;

endmodule

// File: rtl/mmio_switch_input.sv
// Memory-mapped switch-input peripheral: each debounced button press captures the
// switch bank into a FIFO that the CPU drains through a 4-register load/store window.
module mmio_switch_input
   import mmio_pkg::*;
#(
   parameter int         DEPTH     = 8,
   parameter int         SW_W      = 6,
   parameter int         DB_CYCLES = 16,
   parameter logic [5:0] BASE      = 6'h3C
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SW_W-1:0] sw,
   input  logic            btn,
   input  logic [5:0]      bus_addr,
   input  logic            bus_re,
   input  logic            bus_we,
   input  logic [31:0]     bus_wdata,
   output logic [31:0]     bus_rdata,
   output logic            irq
);

   localparam int              AW       = $clog2(DEPTH);
   localparam int              CNTW     = AW + 1;
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

   logic [SW_W-1:0] sw_sync;
   logic            accept;

   btn_debounce #(
      .SW_W      (SW_W),
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn),
      .sw      (sw),
      .sw_sync (sw_sync),
      .accept  (accept)
   );

   logic [SW_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            en_q, en_d;
   logic [15:0]     evcnt_q, evcnt_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            irq_q, irq_d;

   logic        sel, rd_hit, wr_hit, empty, full, flush, pop, push;
   logic [1:0]  off;
   logic [31:0] status;
   logic        unused_wdata;

   assign unused_wdata = ^bus_wdata[31:2];

   always_comb begin
      sel    = (bus_addr[5:2] == BASE[5:2]);
      off    = bus_addr[1:0];
      rd_hit = sel && bus_re;
      wr_hit = sel && bus_we;
      empty  = (count_q == '0);
      full   = (count_q == FULL_CNT);
      flush  = wr_hit && (off == OFF_CTRL) && bus_wdata[CTRL_FLUSH];
      pop    = rd_hit && (off == OFF_DATA) && !empty;
      // A same-cycle pop frees the slot, so a full FIFO can still take the push.
      push   = accept && en_q && (!full || pop) && !flush;

      status                                = '0;
      status[STAT_NONEMPTY]                 = !empty;
      status[STAT_FULL]                     = full;
      status[STAT_OVF]                      = ovf_q;
      status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(count_q);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      en_d     = en_q;
      evcnt_d  = evcnt_q + 16'(accept);
      rdata_d  = '0;
      irq_d    = !empty;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
      if (accept && en_q && full && !pop && !flush) ovf_d = 1'b1;

      if (wr_hit && (off == OFF_CTRL)) en_d = bus_wdata[CTRL_EN];
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end

      // Read data is built from pre-edge state, so same-edge pops/writes are not visible.
      if (rd_hit) begin
         unique case (off)
            OFF_DATA:   rdata_d = empty ? '0 : 32'(mem_q[rd_ptr_q]);
            OFF_STATUS: rdata_d = status;
            OFF_CTRL:   rdata_d = {31'd0, en_q};
            OFF_EVCNT:  rdata_d = {16'd0, evcnt_q};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         en_q     <= 1'b1;
         evcnt_q  <= '0;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         en_q     <= en_d;
         evcnt_q  <= evcnt_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; stale entries are never
   // visible because every read is qualified by count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= sw_sync;
   end

   assign bus_rdata = rdata_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_mmio_switch_input.sv
// Directed self-checking bench for mmio_switch_input with hand-computed expectations.
module tb_mmio_switch_input;

   localparam int         DEPTH     = 8;
   localparam int         SW_W      = 6;
   localparam int         DB_CYCLES = 16;
   localparam logic [5:0] A_DATA    = 6'h3C;
   localparam logic [5:0] A_STATUS  = 6'h3D;
   localparam logic [5:0] A_CTRL    = 6'h3E;
   localparam logic [5:0] A_EVCNT   = 6'h3F;

   logic            clk;
   logic            rst;
   logic [SW_W-1:0] sw;
   logic            btn;
   logic [5:0]      bus_addr;
   logic            bus_re;
   logic            bus_we;
   logic [31:0]     bus_wdata;
   logic [31:0]     bus_rdata;
   logic            irq;

   int total = 0;
   int bad   = 0;

   mmio_switch_input #(
      .DEPTH     (DEPTH),
      .SW_W      (SW_W),
      .DB_CYCLES (DB_CYCLES),
      .BASE      (6'h3C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .btn       (btn),
      .bus_addr  (bus_addr),
      .bus_re    (bus_re),
      .bus_we    (bus_we),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; btn = 1'b0; bus_re = 1'b0; bus_we = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic bus_read(input logic [5:0] addr, output logic [31:0] d);
      bus_addr = addr; bus_re = 1'b1;
      tick(1);
      bus_re = 1'b0; bus_addr = '0;
      d = bus_rdata;
   endtask

   task automatic bus_write(input logic [5:0] addr, input logic [31:0] data);
      bus_addr = addr; bus_wdata = data; bus_we = 1'b1;
      tick(1);
      bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
   endtask

   task automatic press(input logic [SW_W-1:0] v);
      sw = v; btn = 1'b1;
      tick(DB_CYCLES + 5);
      btn = 1'b0;
      tick(DB_CYCLES + 10);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      rst = 1'b1; sw = '0; btn = 1'b0; bus_addr = '0;
      bus_re = 1'b0; bus_we = 1'b0; bus_wdata = '0;

      // Reset state
      do_reset();
      check("rst_rdata", bus_rdata, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'h0);
      bus_read(A_STATUS, d); check("rst_status", d, 32'h0);
      bus_read(A_CTRL, d);   check("rst_ctrl", d, 32'h1);
      bus_read(A_EVCNT, d);  check("rst_evcnt", d, 32'h0);

      // Clean press captures sw=0x2A
      press(6'h2A);
      bus_read(A_STATUS, d); check("press_status", d, 32'h11);
      check("press_irq", {31'd0, irq}, 32'h1);
      bus_read(A_EVCNT, d);  check("press_evcnt", d, 32'h1);
      bus_read(A_DATA, d);   check("press_data", d, 32'h2A);
      bus_read(A_STATUS, d); check("pop_status", d, 32'h0);
      check("pop_irq", {31'd0, irq}, 32'h0);

      // Bounce shorter than DB_CYCLES produces nothing
      do_reset();
      for (int i = 0; i < 40; i++) begin
         btn = ((i / 3) % 2) == 0;
         tick(1);
      end
      btn = 1'b0;
      tick(30);
      bus_read(A_EVCNT, d);  check("bounce_evcnt", d, 32'h0);
      bus_read(A_STATUS, d); check("bounce_status", d, 32'h0);

      // Nine presses into an 8-deep FIFO
      for (int i = 1; i <= 9; i++) press(6'(i));
      bus_read(A_STATUS, d); check("fill_status", d, 32'h87);
      bus_read(A_EVCNT, d);  check("fill_evcnt", d, 32'h9);
      for (int i = 1; i <= 8; i++) begin
         bus_read(A_DATA, d); check($sformatf("drain_%0d", i), d, 32'(i));
      end
      bus_read(A_DATA, d);   check("drain_empty", d, 32'h0);
      bus_read(A_STATUS, d); check("drain_status", d, 32'h04);

      // Flush clears overflow, then accept coincides with a DATA read while full
      bus_write(A_CTRL, 32'h3);
      bus_read(A_STATUS, d); check("flush1_status", d, 32'h0);
      for (int i = 0; i < 8; i++) press(6'(8'h10 + i));
      bus_read(A_STATUS, d); check("full_status", d, 32'h83);
      sw = 6'h18; btn = 1'b1;
      tick(19);
      bus_read(A_DATA, d);   check("coinc_data", d, 32'h10);
      tick(2);
      btn = 1'b0;
      tick(DB_CYCLES + 10);
      bus_read(A_STATUS, d); check("coinc_status", d, 32'h83);
      bus_read(A_EVCNT, d);  check("coinc_evcnt", d, 32'd18);
      bus_write(A_CTRL, 32'h3);
      bus_read(A_STATUS, d); check("flush2_status", d, 32'h0);
      bus_read(A_CTRL, d);   check("flush2_ctrl", d, 32'h1);

      // Disabled capture, unselected accesses, simultaneous read/write
      do_reset();
      bus_write(A_CTRL, 32'h0);
      bus_read(A_CTRL, d);   check("dis_ctrl", d, 32'h0);
      press(6'h15);
      bus_read(A_EVCNT, d);  check("dis_evcnt", d, 32'h1);
      bus_read(A_STATUS, d); check("dis_status", d, 32'h0);
      bus_read(6'h10, d);    check("unsel_read", d, 32'h0);
      bus_write(6'h12, 32'h1);
      bus_read(A_CTRL, d);   check("unsel_ctrl", d, 32'h0);
      bus_read(A_EVCNT, d);  check("unsel_evcnt", d, 32'h1);
      bus_addr = A_CTRL; bus_wdata = 32'h1; bus_re = 1'b1; bus_we = 1'b1;
      tick(1);
      bus_re = 1'b0; bus_we = 1'b0; bus_addr = '0;
      check("rw_pre_ctrl", bus_rdata, 32'h0);
      bus_read(A_CTRL, d);   check("rw_post_ctrl", d, 32'h1);

      // Reset mid-debounce with two entries queued
      do_reset();
      press(6'h05);
      press(6'h06);
      bus_read(A_STATUS, d); check("pre_rst_status", d, 32'h21);
      sw = 6'h33; btn = 1'b1;
      tick(8);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mid_rst_irq", {31'd0, irq}, 32'h0);
      check("mid_rst_rdata", bus_rdata, 32'h0);
      bus_read(A_STATUS, d); check("mid_rst_status", d, 32'h0);
      bus_read(A_EVCNT, d);  check("mid_rst_evcnt", d, 32'h0);
      bus_read(A_CTRL, d);   check("mid_rst_ctrl", d, 32'h1);
      tick(12);
      bus_read(A_STATUS, d); check("early_status", d, 32'h0);
      tick(8);
      btn = 1'b0;
      tick(DB_CYCLES + 10);
      bus_read(A_STATUS, d); check("repress_status", d, 32'h11);
      bus_read(A_EVCNT, d);  check("repress_evcnt", d, 32'h1);
      bus_read(A_DATA, d);   check("repress_data", d, 32'h33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
